// File: rtl/fg_waveform_ctrl.sv
// Configuration shadow/active register bank, prescaled tick and period sequencer
// feeding the function-generator waveform datapath.
module fg_waveform_ctrl #(
    parameter int unsigned COUNTER_BITWIDTH  = 32,
    parameter int unsigned WAVEFORM_BITWIDTH = 16,
    parameter int unsigned PRESCALE_BITWIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         cfg_valid_i,
    output logic                         cfg_ready_o,
    input  logic [2:0]                   cfg_addr_i,
    input  logic [COUNTER_BITWIDTH-1:0]  cfg_data_i,
    output logic                         clk_en_o,
    output logic [COUNTER_BITWIDTH-1:0]  CR_o,
    output logic [COUNTER_BITWIDTH-1:0]  counter_o,
    output logic [COUNTER_BITWIDTH-1:0]  ON_counter_o,
    output logic [WAVEFORM_BITWIDTH-1:0] k_rise_o,
    output logic [WAVEFORM_BITWIDTH-1:0] k_fall_o,
    output logic [WAVEFORM_BITWIDTH-1:0] amplitude_o,
    output logic                         period_start_o,
    output logic                         busy_o
);
    localparam int unsigned CW = COUNTER_BITWIDTH;
    localparam int unsigned WW = WAVEFORM_BITWIDTH;
    localparam int unsigned PW = PRESCALE_BITWIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   sh_period_q, sh_period_d, sh_on_q, sh_on_d;
    logic [WW-1:0]   sh_k_rise_q, sh_k_rise_d, sh_k_fall_q, sh_k_fall_d, sh_amp_q, sh_amp_d;
    logic [PW-1:0]   sh_pre_q, sh_pre_d;
    logic [1:0]      sh_ctrl_q, sh_ctrl_d;
    logic [CW-1:0]   act_period_q, act_period_d, act_on_q, act_on_d;
    logic [WW-1:0]   act_k_rise_q, act_k_rise_d, act_k_fall_q, act_k_fall_d, act_amp_q, act_amp_d;
    logic [PW-1:0]   act_pre_q, act_pre_d;
    logic [PW-1:0]   pre_cnt_q, pre_cnt_d;
    logic [CW-1:0]   cr_q, cr_d;
    logic            tick_c, wrap_c, wr_en_c;

    // Tick, wrap and handshake decode, all from registered state
    assign tick_c         = (state_q == ST_RUN) && (pre_cnt_q == act_pre_q);
    assign wrap_c         = tick_c && (cr_q == act_period_q);
    assign cfg_ready_o    = (state_q != ST_ARM) && !wrap_c;
    assign wr_en_c        = cfg_valid_i && cfg_ready_o;
    assign clk_en_o       = tick_c;
    assign period_start_o = tick_c && (cr_q == '0);
    assign busy_o         = (state_q != ST_IDLE);
    assign CR_o           = cr_q;
    assign counter_o      = act_period_q;
    assign ON_counter_o   = act_on_q;
    assign k_rise_o       = act_k_rise_q;
    assign k_fall_o       = act_k_fall_q;
    assign amplitude_o    = act_amp_q;

    always_comb begin
        state_d      = state_q;
        sh_period_d  = sh_period_q;
        sh_on_d      = sh_on_q;
        sh_k_rise_d  = sh_k_rise_q;
        sh_k_fall_d  = sh_k_fall_q;
        sh_amp_d     = sh_amp_q;
        sh_pre_d     = sh_pre_q;
        sh_ctrl_d    = sh_ctrl_q;
        act_period_d = act_period_q;
        act_on_d     = act_on_q;
        act_k_rise_d = act_k_rise_q;
        act_k_fall_d = act_k_fall_q;
        act_amp_d    = act_amp_q;
        act_pre_d    = act_pre_q;
        pre_cnt_d    = pre_cnt_q;
        cr_d         = cr_q;

        if (wr_en_c) begin
            case (cfg_addr_i)
                3'd0:    sh_period_d = cfg_data_i;
                3'd1:    sh_on_d     = cfg_data_i;
                3'd2:    sh_k_rise_d = cfg_data_i[WW-1:0];
                3'd3:    sh_k_fall_d = cfg_data_i[WW-1:0];
                3'd4:    sh_amp_d    = cfg_data_i[WW-1:0];
                3'd5:    sh_pre_d    = cfg_data_i[PW-1:0];
                3'd6:    sh_ctrl_d   = cfg_data_i[1:0];
                default: ;
            endcase
        end

        // Commit happens in ARM and on every wrap tick; writes are stalled in both
        if ((state_q == ST_ARM) || wrap_c) begin
            act_period_d = sh_period_q;
            act_on_d     = sh_on_q;
            act_k_rise_d = sh_k_rise_q;
            act_k_fall_d = sh_k_fall_q;
            act_amp_d    = sh_amp_q;
            act_pre_d    = sh_pre_q;
        end

        case (state_q)
            ST_IDLE: begin
                pre_cnt_d = '0;
                cr_d      = '0;
                if (sh_ctrl_q[0]) state_d = ST_ARM;
            end
            ST_ARM: begin
                pre_cnt_d = '0;
                cr_d      = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (tick_c) begin
                    pre_cnt_d = '0;
                    if (wrap_c) begin
                        cr_d = '0;
                        if (!sh_ctrl_q[0] || sh_ctrl_q[1]) state_d = ST_IDLE;
                        if (sh_ctrl_q[1]) sh_ctrl_d[0] = 1'b0;
                    end else begin
                        cr_d = cr_q + CW'(1);
                    end
                end else begin
                    pre_cnt_d = pre_cnt_q + PW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            sh_period_q  <= '0;
            sh_on_q      <= '0;
            sh_k_rise_q  <= '0;
            sh_k_fall_q  <= '0;
            sh_amp_q     <= '0;
            sh_pre_q     <= '0;
            sh_ctrl_q    <= '0;
            act_period_q <= '0;
            act_on_q     <= '0;
            act_k_rise_q <= '0;
            act_k_fall_q <= '0;
            act_amp_q    <= '0;
            act_pre_q    <= '0;
            pre_cnt_q    <= '0;
            cr_q         <= '0;
        end else begin
            state_q      <= state_d;
            sh_period_q  <= sh_period_d;
            sh_on_q      <= sh_on_d;
            sh_k_rise_q  <= sh_k_rise_d;
            sh_k_fall_q  <= sh_k_fall_d;
            sh_amp_q     <= sh_amp_d;
            sh_pre_q     <= sh_pre_d;
            sh_ctrl_q    <= sh_ctrl_d;
            act_period_q <= act_period_d;
            act_on_q     <= act_on_d;
            act_k_rise_q <= act_k_rise_d;
            act_k_fall_q <= act_k_fall_d;
            act_amp_q    <= act_amp_d;
            act_pre_q    <= act_pre_d;
            pre_cnt_q    <= pre_cnt_d;
            cr_q         <= cr_d;
        end
    end

endmodule
